// File: rtl/chacha_pkg.sv
// Shared definitions for the chunk transmit sequencer: FSM encoding, mode
// constants and the default watchdog budget.
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BLK  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_LAST = 3'd3,
        ST_GAP       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    localparam logic ENCRYP         = 1'b0;
    localparam logic DECRYP         = 1'b1;
    localparam int   WDT_CYCLES_DEF = 1024;
    localparam int   CTR_W          = 64;
    localparam int   BLK_W          = 512;

    // Block counter for the n-th block of a message; wraps modulo 2^64.
    function automatic logic [CTR_W-1:0] block_counter(
        input logic [CTR_W-1:0] base,
        input logic [CTR_W-1:0] idx
    );
        return base + idx;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts while enabled, expire fires on the cycle whose edge
// brings the count to WDT_CYCLES-1.
module seq_watchdog
    import chacha_pkg::*;
#(
    parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic seq_clk,
    input  logic seq_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] CNT_MAX = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] CNT_PRE = WDT_W'(WDT_CYCLES - 2);

    logic [WDT_W-1:0] count_r;

    // Saturating cycle counter, held at zero while cleared.
    always_ff @(posedge seq_clk or negedge seq_reset_n) begin
        if (!seq_reset_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + WDT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && !clear && (count_r == CNT_PRE);

endmodule

// File: rtl/chunk_tx_sequencer.sv
// Feeds 512-bit cipher blocks to the chunk divider one at a time, tagging each
// with its block counter and mode, and supervises each block with a watchdog.
module chunk_tx_sequencer
    import chacha_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic              seq_clk,
    input  logic              seq_reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [CTR_W-1:0]  init_counter,
    input  logic              abort,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_data,
    output logic              div_valid,
    output logic [BLK_W-1:0]  div_data,
    output logic [CTR_W-1:0]  div_counter,
    output logic              div_mode,
    input  logic              div_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  blocks_sent
);

    seq_state_t        state_r;
    logic              mode_r;
    logic [CNT_W-1:0]  num_r;
    logic [CTR_W-1:0]  init_r;
    logic [CNT_W-1:0]  sent_r;
    logic [CNT_W-1:0]  sent_inc_s;
    logic [BLK_W-1:0]  div_data_r;
    logic [CTR_W-1:0]  div_counter_r;
    logic              div_mode_r;
    logic              done_r;
    logic              err_r;
    logic              wdt_clear_s;
    logic              wdt_enable_s;
    logic              wdt_expire_s;

    assign wdt_enable_s = (state_r == ST_WAIT_LAST);
    assign wdt_clear_s  = (state_r != ST_WAIT_LAST);

    seq_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .seq_clk     (seq_clk),
        .seq_reset_n (seq_reset_n),
        .clear       (wdt_clear_s),
        .enable      (wdt_enable_s),
        .expire      (wdt_expire_s)
    );

    // Completed-block count saturates at the requested block count.
    always_comb begin
        sent_inc_s = sent_r;
        if (sent_r < num_r) begin
            sent_inc_s = sent_r + CNT_W'(1);
        end else begin
            sent_inc_s = sent_r;
        end
    end

    // Message sequencing FSM; abort takes priority over every other event.
    always_ff @(posedge seq_clk or negedge seq_reset_n) begin
        if (!seq_reset_n) begin
            state_r       <= ST_IDLE;
            mode_r        <= ENCRYP;
            num_r         <= '0;
            init_r        <= '0;
            sent_r        <= '0;
            div_data_r    <= '0;
            div_counter_r <= '0;
            div_mode_r    <= ENCRYP;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= (mode == DECRYP) ? DECRYP : ENCRYP;
                        num_r  <= num_blocks;
                        init_r <= init_counter;
                        sent_r <= '0;
                        err_r  <= 1'b0;
                        if (num_blocks == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT_BLK;
                        end
                    end
                end
                ST_WAIT_BLK: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (blk_valid) begin
                        div_data_r    <= blk_data;
                        div_counter_r <= block_counter(init_r, CTR_W'(sent_r));
                        div_mode_r    <= mode_r;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= abort ? ST_IDLE : ST_WAIT_LAST;
                end
                ST_WAIT_LAST: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (div_last) begin
                        sent_r  <= sent_inc_s;
                        state_r <= ST_GAP;
                    end else if (wdt_expire_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_FAULT;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (sent_r < num_r) begin
                        state_r <= ST_WAIT_BLK;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_r != ST_IDLE);
    assign blk_ready   = (state_r == ST_WAIT_BLK);
    assign div_valid   = (state_r == ST_ISSUE);
    assign div_data    = div_data_r;
    assign div_counter = div_counter_r;
    assign div_mode    = div_mode_r;
    assign done        = done_r;
    assign err         = err_r;
    assign blocks_sent = sent_r;

endmodule

// File: tb/tb_chunk_tx_sequencer.sv
// Self-checking bench: behavioural message model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_chunk_tx_sequencer;

    localparam int WDT_MAIN = 32;
    localparam int R_HOLD = 0, R_RANDOM = 1, R_FIXED = 2, R_MANUAL = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start, mode, abort, blk_valid, div_last;
    logic [15:0]  num_blocks;
    logic [63:0]  init_counter;
    logic [511:0] blk_data;

    logic         blk_ready, div_valid, div_mode, busy, done, err;
    logic [511:0] div_data;
    logic [63:0]  div_counter;
    logic [15:0]  blocks_sent;

    logic         d16_blk_ready, d16_div_valid, d16_div_mode, d16_busy, d16_done, d16_err;
    logic [511:0] d16_div_data;
    logic [63:0]  d16_div_counter;
    logic [15:0]  d16_blocks_sent;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;

    chunk_tx_sequencer #(.CNT_W(16), .WDT_CYCLES(WDT_MAIN)) dut (
        .seq_clk(clk), .seq_reset_n(rst_n), .start(start), .mode(mode),
        .num_blocks(num_blocks), .init_counter(init_counter), .abort(abort),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .div_valid(div_valid), .div_data(div_data), .div_counter(div_counter),
        .div_mode(div_mode), .div_last(div_last), .busy(busy), .done(done),
        .err(err), .blocks_sent(blocks_sent)
    );

    chunk_tx_sequencer #(.CNT_W(16), .WDT_CYCLES(16)) dut16 (
        .seq_clk(clk), .seq_reset_n(rst_n), .start(start), .mode(mode),
        .num_blocks(num_blocks), .init_counter(init_counter), .abort(abort),
        .blk_valid(blk_valid), .blk_ready(d16_blk_ready), .blk_data(blk_data),
        .div_valid(d16_div_valid), .div_data(d16_div_data), .div_counter(d16_div_counter),
        .div_mode(d16_div_mode), .div_last(div_last), .busy(d16_busy), .done(d16_done),
        .err(d16_err), .blocks_sent(d16_blocks_sent)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model of the main instance ----------------
    logic         m_busy = 1'b0, m_want = 1'b0, m_issue = 1'b0, m_wait = 1'b0;
    logic         m_gap = 1'b0, m_done = 1'b0, m_err = 1'b0, m_mode = 1'b0, m_dmode = 1'b0;
    logic [15:0]  m_num = '0, m_sent = '0;
    logic [63:0]  m_init = '0, m_cnt = '0;
    logic [511:0] m_data = '0;
    int           m_age = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_want <= 1'b0; m_issue <= 1'b0; m_wait <= 1'b0;
            m_gap <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_mode <= 1'b0; m_dmode <= 1'b0;
            m_num <= '0; m_sent <= '0; m_init <= '0; m_cnt <= '0; m_data <= '0; m_age <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_mode <= mode; m_num <= num_blocks; m_init <= init_counter;
                    m_sent <= '0; m_err <= 1'b0;
                    if (num_blocks == 16'd0) m_done <= 1'b1;
                    else begin m_busy <= 1'b1; m_want <= 1'b1; end
                end
            end else if (abort) begin
                m_busy <= 1'b0; m_want <= 1'b0; m_issue <= 1'b0; m_wait <= 1'b0; m_gap <= 1'b0;
            end else if (m_want) begin
                if (blk_valid) begin
                    m_want <= 1'b0; m_issue <= 1'b1; m_data <= blk_data;
                    m_cnt <= m_init + {48'd0, m_sent}; m_dmode <= m_mode;
                end
            end else if (m_issue) begin
                m_issue <= 1'b0; m_wait <= 1'b1; m_age <= 1;
            end else if (m_wait) begin
                if (div_last) begin
                    m_wait <= 1'b0; m_gap <= 1'b1;
                    if (m_sent < m_num) m_sent <= m_sent + 16'd1;
                end else begin
                    m_age <= m_age + 1;
                    if (m_age + 1 == WDT_MAIN) begin m_wait <= 1'b0; m_err <= 1'b1; end
                end
            end else if (m_gap) begin
                m_gap <= 1'b0;
                if (m_sent < m_num) m_want <= 1'b1;
                else begin m_busy <= 1'b0; m_done <= 1'b1; end
            end
            // otherwise faulted: only abort leaves
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        n_vec++;
        if ({busy, blk_ready, div_valid, done, err, div_mode} !== {m_busy, m_want, m_issue, m_done, m_err, m_dmode}
            || blocks_sent !== m_sent || div_counter !== m_cnt || div_data !== m_data) begin
            n_bad++;
            $display("FAIL cycle_compare @%0d (dut/model): busy %b/%b rdy %b/%b vld %b/%b done %b/%b err %b/%b mode %b/%b sent %0d/%0d ctr %h/%h data_eq %b",
                     cyc_n, busy, m_busy, blk_ready, m_want, div_valid, m_issue, done, m_done, err, m_err,
                     div_mode, m_dmode, blocks_sent, m_sent, div_counter, m_cnt, div_data === m_data);
        end
    end

    // ---------------- monitors ----------------
    logic [63:0] vq[$];
    int vcyc[$];
    int lastq[$];
    int done_cnt = 0, val_cnt = 0, rdy_cnt = 0;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (div_last) lastq.push_back(cyc_n + 1);
    end

    always @(negedge clk) begin
        if (div_valid) begin vq.push_back(div_counter); vcyc.push_back(cyc_n); val_cnt++; end
        if (done) done_cnt++;
        if (blk_ready) rdy_cnt++;
    end

    // ---------------- divider responder ----------------
    int resp_mode = R_HOLD;
    int resp_delay = 18;
    logic manual_last = 1'b0;
    int r_k = 0;
    bit r_armed = 1'b0;

    always @(negedge clk) begin
        case (resp_mode)
            R_RANDOM: begin div_last = ($urandom_range(0, 7) == 0); r_armed = 1'b0; end
            R_FIXED: begin
                if (div_valid) begin r_armed = 1'b1; r_k = 0; div_last = 1'b0; end
                else if (r_armed) begin
                    r_k++;
                    div_last = (r_k == resp_delay);
                    if (r_k == resp_delay) r_armed = 1'b0;
                end else div_last = 1'b0;
            end
            R_MANUAL: begin div_last = manual_last; r_armed = 1'b0; end
            default:  begin div_last = 1'b0; r_armed = 1'b0; end
        endcase
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_mon();
        vq.delete(); vcyc.delete(); lastq.delete();
        done_cnt = 0; val_cnt = 0; rdy_cnt = 0;
    endtask

    task automatic quiesce();
        start = 1'b0; blk_valid = 1'b0; resp_mode = R_HOLD; manual_last = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        clear_mon();
    endtask

    task automatic do_start(input logic [15:0] n, input logic [63:0] ic, input logic md);
        start = 1'b1; num_blocks = n; init_counter = ic; mode = md;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (div_valid) begin found = 1'b1; break; end
        end
        check(name, 64'(found), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ic;
        int t0, t1;
        bit found;
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; abort = 1'b0; blk_valid = 1'b0;
        num_blocks = '0; init_counter = '0; blk_data = '0;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", {blk_ready, div_valid, done, err, div_mode, blocks_sent}, 64'd0);
        check("rst_counter", div_counter, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // zero-block message: done one cycle after start, nothing else
        clear_mon();
        do_start(16'd0, 64'h1234, 1'b0);
        check("s037_done_pulse", 64'(done), 64'd1);
        check("s037_busy", 64'(busy), 64'd0);
        tick();
        check("s037_done_single", 64'(done), 64'd0);
        repeat (4) tick();
        check("s037_no_ready", 64'(rdy_cnt), 64'd0);
        check("s037_no_valid", 64'(val_cnt), 64'd0);
        check("s037_done_count", 64'(done_cnt), 64'd1);

        // watchdog on the WDT_CYCLES=16 instance
        quiesce();
        ic = {$urandom, $urandom};
        do_start(16'd2, ic, 1'b1);
        blk_valid = 1'b1; blk_data = rand512();
        found = 1'b0; t0 = 0; t1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (d16_div_valid) begin t0 = cyc_n; found = 1'b1; break; end
        end
        check("s038_valid_seen", 64'(found), 64'd1);
        blk_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (d16_err) begin t1 = cyc_n; found = 1'b1; break; end
        end
        check("s038_err_seen", 64'(found), 64'd1);
        check("s038_fault_latency", 64'(t1 - t0), 64'd16);
        check("s038_busy_in_fault", 64'(d16_busy), 64'd1);
        check("s038_quiet_in_fault", {d16_blk_ready, d16_div_valid, d16_done, d16_blocks_sent}, 64'd0);
        check("s038_mode", 64'(d16_div_mode), 64'd1);
        check("s038_counter", d16_div_counter, ic);
        check("s038_data", 64'(d16_div_data === m_data), 64'd1);
        check("s038_main_no_err", 64'(err), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s038_idle_after_abort", 64'(d16_busy), 64'd0);
        check("s038_err_held", 64'(d16_err), 64'd1);
        tick();
        check("s038_err_still_held", 64'(d16_err), 64'd1);

        // three blocks, divider answers 18 cycles after each load
        quiesce();
        resp_mode = R_FIXED; resp_delay = 18;
        do_start(16'd3, 64'h5, 1'b0);
        blk_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            blk_data = rand512();
            tick();
            if (done_cnt != 0) break;
        end
        blk_valid = 1'b0;
        repeat (3) tick();
        check("s035_num_valid", 64'(vq.size()), 64'd3);
        for (int i = 0; i < vq.size() && i < 3; i++) check("s035_counter", vq[i], 64'(5 + i));
        for (int i = 1; i < vcyc.size() && i <= lastq.size(); i++)
            check("s035_gap_edges", 64'(vcyc[i] - lastq[i-1] >= 2), 64'd1);
        check("s035_done_count", 64'(done_cnt), 64'd1);
        check("s035_blocks_sent", 64'(blocks_sent), 64'd3);
        check("s035_model_sent", 64'(m_sent), 64'd3);
        check("s035_no_err", 64'(err), 64'd0);

        // counter wrap
        quiesce();
        resp_mode = R_FIXED; resp_delay = 3;
        do_start(16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        blk_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            blk_data = rand512();
            tick();
            if (done_cnt != 0) break;
        end
        blk_valid = 1'b0;
        tick();
        check("s036_num_valid", 64'(vq.size()), 64'd2);
        if (vq.size() >= 2) begin
            check("s036_counter0", vq[0], 64'hFFFF_FFFF_FFFF_FFFF);
            check("s036_counter1", vq[1], 64'h0);
        end
        check("s036_mode", 64'(div_mode), 64'd1);

        // abort and div_last in the same cycle
        quiesce();
        resp_mode = R_MANUAL;
        do_start(16'd3, {$urandom, $urandom}, 1'b0);
        blk_valid = 1'b1; blk_data = rand512();
        wait_valid("s039_valid_seen");
        blk_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1; manual_last = 1'b1;
        tick();
        abort = 1'b0; manual_last = 1'b0;
        check("s039_idle", 64'(busy), 64'd0);
        check("s039_sent_unchanged", 64'(blocks_sent), 64'd0);
        check("s039_no_done", 64'(done), 64'd0);
        repeat (2) tick();
        check("s039_done_count", 64'(done_cnt), 64'd0);

        // asynchronous reset in WAIT_LAST, then a fresh message
        quiesce();
        do_start(16'd2, {$urandom, $urandom}, 1'b1);
        blk_valid = 1'b1; blk_data = rand512() | 512'd1;
        wait_valid("s040_valid_seen");
        blk_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("s040_rst_ctrl", {busy, blk_ready, div_valid, done, err, div_mode, blocks_sent}, 64'd0);
        check("s040_rst_counter", div_counter, 64'd0);
        check("s040_rst_data", 64'(div_data == '0), 64'd1);
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        check("s040_no_valid_after_rst", 64'(val_cnt), 64'd0);
        ic = {$urandom, $urandom};
        resp_mode = R_FIXED; resp_delay = 2;
        do_start(16'd1, ic, 1'b0);
        blk_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_cnt != 0) break;
        end
        blk_valid = 1'b0;
        check("s040_restart_valid", 64'(vq.size()), 64'd1);
        if (vq.size() >= 1) check("s040_restart_counter", vq[0], ic);

        // randomized traffic against the model
        quiesce();
        resp_mode = R_RANDOM;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            num_blocks = 16'($urandom_range(0, 3));
            init_counter = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2)))
                                                      : {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 79) == 0);
            blk_valid = 1'($urandom_range(0, 1));
            blk_data = rand512();
            tick();
        end
        quiesce();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
